// File: rtl/nmux_pipe.sv
`default_nettype none
// ============================================================================
// Module   : nmux_pipe
// Brief    : CH-way W-bit word selector feeding a STAGES-deep register pipe
//            with stall (freeze), flush (bubble) and valid/select tracking.
// Revision : 1.0
// ============================================================================
module nmux_pipe #(
  parameter int W      = 32,
  parameter int CH     = 4,
  parameter int STAGES = 1,
  localparam int SW    = $clog2(CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH*W-1:0] in_bus,
  input  logic [SW-1:0]   sel,
  input  logic            in_valid,
  input  logic            stall,
  input  logic            flush,
  output logic [W-1:0]    out,
  output logic            out_valid,
  output logic [SW-1:0]   out_sel,
  output logic            err
);

  logic [W-1:0]  w_word;
  logic          w_oor;

  logic [W-1:0]  r_data [STAGES];
  logic [SW-1:0] r_tag  [STAGES];
  logic          r_vld  [STAGES];
  logic          r_err;

  // Out-of-range selects fall through every compare and yield an all-zero word.
  always_comb begin
    w_word = '0;
    for (int k = 0; k < CH; k++) begin
      if (sel == SW'(k)) begin
        w_word = in_bus[k*W +: W];
      end
    end
    w_oor = (32'(sel) >= 32'(CH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        r_data[i] <= '0;
        r_tag[i]  <= '0;
        r_vld[i]  <= 1'b0;
      end
      r_err <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < STAGES; i++) begin
        r_data[i] <= '0;
        r_tag[i]  <= '0;
        r_vld[i]  <= 1'b0;
      end
    end else if (!stall) begin
      // Bubbles carry zero data and a zero tag.
      r_data[0] <= in_valid ? w_word : '0;
      r_tag[0]  <= in_valid ? sel    : '0;
      r_vld[0]  <= in_valid;
      for (int i = 1; i < STAGES; i++) begin
        r_data[i] <= r_data[i-1];
        r_tag[i]  <= r_tag[i-1];
        r_vld[i]  <= r_vld[i-1];
      end
      if (in_valid && w_oor) begin
        r_err <= 1'b1;
      end
    end
  end

  assign out       = r_data[STAGES-1];
  assign out_valid = r_vld[STAGES-1];
  assign out_sel   = r_tag[STAGES-1];
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_nmux_pipe.sv
`default_nettype none
// Directed bench for nmux_pipe: four instances cover STAGES=1/3/2 and CH=3.
module tb_nmux_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // a: W32 CH4 S1
  logic [127:0] a_bus = {32'h33333333, 32'hDEADBEEF, 32'h22222222, 32'h11111111};
  logic [1:0]   a_sel = '0;
  logic         a_vld = 1'b0, a_stall = 1'b0, a_flush = 1'b0;
  logic [31:0]  a_out;
  logic         a_ovld, a_err;
  logic [1:0]   a_osel;
  // b: W32 CH4 S3
  logic [127:0] b_bus = {32'h00001003, 32'h00001002, 32'h00001001, 32'h00001000};
  logic [1:0]   b_sel = '0;
  logic         b_vld = 1'b0, b_stall = 1'b0, b_flush = 1'b0;
  logic [31:0]  b_out;
  logic         b_ovld, b_err;
  logic [1:0]   b_osel;
  // c: W32 CH4 S2
  logic [127:0] c_bus = {32'hCCCC3333, 32'hCCCC2222, 32'hBBBB1111, 32'hAAAA0000};
  logic [1:0]   c_sel = '0;
  logic         c_vld = 1'b0, c_stall = 1'b0, c_flush = 1'b0;
  logic [31:0]  c_out;
  logic         c_ovld, c_err;
  logic [1:0]   c_osel;
  // d: W32 CH3 S1
  logic [95:0]  d_bus = {32'h00000003, 32'h00000002, 32'h00000001};
  logic [1:0]   d_sel = '0;
  logic         d_vld = 1'b0, d_stall = 1'b0, d_flush = 1'b0;
  logic [31:0]  d_out;
  logic         d_ovld, d_err;
  logic [1:0]   d_osel;

  nmux_pipe #(.W(32), .CH(4), .STAGES(1)) u_a (
    .clk(clk), .rst(rst), .in_bus(a_bus), .sel(a_sel), .in_valid(a_vld),
    .stall(a_stall), .flush(a_flush), .out(a_out), .out_valid(a_ovld),
    .out_sel(a_osel), .err(a_err));
  nmux_pipe #(.W(32), .CH(4), .STAGES(3)) u_b (
    .clk(clk), .rst(rst), .in_bus(b_bus), .sel(b_sel), .in_valid(b_vld),
    .stall(b_stall), .flush(b_flush), .out(b_out), .out_valid(b_ovld),
    .out_sel(b_osel), .err(b_err));
  nmux_pipe #(.W(32), .CH(4), .STAGES(2)) u_c (
    .clk(clk), .rst(rst), .in_bus(c_bus), .sel(c_sel), .in_valid(c_vld),
    .stall(c_stall), .flush(c_flush), .out(c_out), .out_valid(c_ovld),
    .out_sel(c_osel), .err(c_err));
  nmux_pipe #(.W(32), .CH(3), .STAGES(1)) u_d (
    .clk(clk), .rst(rst), .in_bus(d_bus), .sel(d_sel), .in_valid(d_vld),
    .stall(d_stall), .flush(d_flush), .out(d_out), .out_valid(d_ovld),
    .out_sel(d_osel), .err(d_err));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset ----------------
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_out", a_out, 0);   chk("rst_a_vld", a_ovld, 0);
    chk("rst_a_sel", a_osel, 0);  chk("rst_a_err", a_err, 0);
    chk("rst_b_vld", b_ovld, 0);  chk("rst_c_vld", c_ovld, 0);
    chk("rst_d_err", d_err, 0);
    rst = 1'b0;

    // ---------------- basic, STAGES=1 ----------------
    a_sel = 2'd2; a_vld = 1'b1;
    step();
    chk("basic_out", a_out, 64'hDEADBEEF); chk("basic_vld", a_ovld, 1);
    chk("basic_sel", a_osel, 2);           chk("basic_err", a_err, 0);
    a_sel = 2'd3;
    step();
    chk("basic_ch3", a_out, 64'h33333333); chk("basic_ch3_sel", a_osel, 3);
    a_vld = 1'b0;
    step();
    chk("bubble_out", a_out, 0); chk("bubble_vld", a_ovld, 0);

    // ---------------- streaming, STAGES=3 ----------------
    for (int i = 0; i < 7; i++) begin
      b_vld = (i < 4);
      b_sel = 2'(i);
      step();
      if (i >= 2 && i <= 5) begin
        chk("stream_out", b_out, 64'h1000 + 64'(i - 2));
        chk("stream_vld", b_ovld, 1);
        chk("stream_sel", b_osel, 64'(i - 2));
      end else begin
        chk("stream_idle_vld", b_ovld, 0);
      end
    end
    b_vld = 1'b0;

    // ---------------- stall, STAGES=2 ----------------
    c_vld = 1'b1; c_sel = 2'd0;
    step();
    chk("stall_fill_vld", c_ovld, 0);
    c_sel = 2'd1;
    step();
    chk("stall_A_out", c_out, 64'hAAAA0000);
    c_stall = 1'b1; c_sel = 2'd2;   // ignored while stalled
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold_out", c_out, 64'hAAAA0000);
      chk("stall_hold_vld", c_ovld, 1);
    end
    c_stall = 1'b0; c_vld = 1'b0;
    step();
    chk("stall_B_out", c_out, 64'hBBBB1111); chk("stall_B_sel", c_osel, 1);
    step();
    chk("stall_drain_vld", c_ovld, 0);

    // ---------------- flush over stall, STAGES=2 ----------------
    c_vld = 1'b1; c_sel = 2'd0;
    step();
    c_sel = 2'd1;
    step();
    chk("flush_pre_out", c_out, 64'hAAAA0000);
    c_stall = 1'b1; c_flush = 1'b1; c_sel = 2'd2;
    step();
    chk("flush_vld", c_ovld, 0); chk("flush_out", c_out, 0); chk("flush_sel", c_osel, 0);
    c_stall = 1'b0; c_flush = 1'b0; c_sel = 2'd3;
    step();
    chk("flush_gap_vld", c_ovld, 0);
    c_vld = 1'b0;
    step();
    chk("flush_next_out", c_out, 64'hCCCC3333); chk("flush_next_vld", c_ovld, 1);

    // ---------------- out-of-range, CH=3 ----------------
    d_sel = 2'd3; d_vld = 1'b0;
    step();
    chk("oor_novalid_err", d_err, 0); chk("oor_novalid_vld", d_ovld, 0);
    d_vld = 1'b1; d_stall = 1'b1;
    step();
    chk("oor_stall_err", d_err, 0); chk("oor_stall_vld", d_ovld, 0);
    d_stall = 1'b0; d_flush = 1'b1;
    step();
    chk("oor_flush_err", d_err, 0);
    d_flush = 1'b0;
    step();
    chk("oor_out", d_out, 0); chk("oor_vld", d_ovld, 1);
    chk("oor_sel", d_osel, 3); chk("oor_err", d_err, 1);
    d_sel = 2'd2;
    step();
    chk("oor_after_out", d_out, 3); chk("oor_sticky1", d_err, 1);
    d_sel = 2'd0;
    step();
    chk("oor_after_out2", d_out, 1); chk("oor_sticky2", d_err, 1);
    d_vld = 1'b0;

    // ---------------- async reset mid-stream ----------------
    a_sel = 2'd2; a_vld = 1'b1;
    step();
    chk("arst_pre_vld", a_ovld, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out", a_out, 0);   chk("arst_vld", a_ovld, 0);
    chk("arst_sel", a_osel, 0);  chk("arst_err", d_err, 0);
    #1 rst = 1'b0;
    a_sel = 2'd1;
    step();
    chk("arst_post_out", a_out, 64'h22222222); chk("arst_post_vld", a_ovld, 1);
    a_vld = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nmux_pipe.md
# nmux_pipe

Parametrised, registered N-way word selector for the processor datapath, generalising the combinational 2:1 word mux to CH input channels feeding a STAGES-deep pipeline with stall, flush and valid tracking. It selects one W-bit channel per cycle and launches the word down a short register pipe that the hazard unit freezes or bubbles. Typical uses are the forwarding/operand selection registered into the ID/EX and EX/MEM boundaries.

## Interface
- W, 32, data word width in bits (>=1)
- CH, 4, number of input channels (>=2; need not be a power of two)
- STAGES, 1, pipeline register depth (1..4)
- SW, derived = clog2(CH), select width (localparam)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_bus  in  CH*W  packed channels; channel k = in_bus[k*W +: W]
- sel  in  SW  channel select, sampled with in_valid
- in_valid  in  1  input word valid this cycle
- stall  in  1  hold every stage (pipeline freeze)
- flush  in  1  invalidate every stage (bubble insertion)
- out  out  W  word leaving the last stage
- out_valid  out  1  out holds a valid word
- out_sel  out  SW  channel index that produced out
- err  out  1  sticky: an out-of-range sel was accepted

## Operation
- One clock; reset is asynchronous and active-high. Asserting rst immediately clears every stage: data 0, valid 0, sel tag 0, err 0.
- Stage 0 captures {mux(in_bus, sel), sel, in_valid} on every unstalled edge; stage i captures stage i-1. Output ports are driven directly from stage STAGES-1 (no combinational path from inputs to outputs).
- Mux: sel < CH selects channel sel. When sel >= CH (possible only if CH is not a power of two), the word is all zeros; if in_valid is also 1 at an accepted edge, err sets and stays set until rst.
- When in_valid=0 the stage still captures, but with valid=0 and data forced to 0 (bubbles carry zero).
- stall=1, flush=0: no stage changes; in_valid/sel are ignored that cycle (the upstream holds them).
- flush=1: at the edge all stages load valid=0, data=0, tag=0, regardless of stall; the input word presented in that cycle is dropped. Flush has priority over stall.
- err is not affected by stall-ignored or flushed inputs.
- Arithmetic: none; width-exact selection, no sign or zero extension.

## Timing
- Latency: a word accepted at edge t appears on out/out_valid/out_sel after edge t+STAGES-1, i.e. it is visible STAGES cycles after it was presented, plus one cycle per stalled cycle in between.
- Throughput: one word per unstalled cycle; no gaps between back-to-back valid words.
- Stall is level-sensitive, with no minimum or maximum length; outputs are stable for its whole duration.
- A flush in cycle t yields out_valid=0 from edge t for STAGES cycles unless new valid words arrive; the first post-flush word appears STAGES cycles after it is presented.
- rst deasserted mid-stream: the first edge after release behaves as a normal capture.
- Stall and flush asserted on the same edge: flush result.

## Test plan
- Reset/basic: W=32, CH=4, STAGES=1. Hold rst, then release; present ch2=0xDEADBEEF with sel=2 and in_valid=1 -> next cycle out=0xDEADBEEF, out_valid=1, out_sel=2, err=0.
- Streaming depth: STAGES=3. Present sel=0,1,2,3 on consecutive cycles with channel k=0x1000+k -> out shows 0x1000..0x1003 on cycles 3..6 with out_valid=1 throughout.
- Stall: STAGES=2. Stream words A, B and assert stall for 3 cycles while B is in stage 0 -> out stays A for 3 extra cycles, then B follows; no word is lost or duplicated.
- Flush priority: pipe full (STAGES=2) with stall=1 and flush=1 on the same cycle -> next cycle out_valid=0 and out=0; the next valid word appears 2 cycles later.
- Out-of-range: CH=3 (SW=2). Present sel=3 with in_valid=1 -> out=0 and err=1, and err stays set after further valid traffic. Presenting sel=3 with in_valid=0 or under stall does not set err.
- Async reset mid-stream: assert rst between clock edges while out_valid=1 -> out, out_valid, out_sel and err all go to 0 before the next edge.
